fifo_sync: RTL and testbench

Parametrised single-clock FIFO: the next generation of the team's FIFO family for same-domain buffering between pipeline stages. It adds the following over the earlier FIFO:
- a selectable read mode (registered or first-word-fall-through)
- an exact fill level
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a synchronous flush

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_sync_if.sv | 29 ++
 rtl/fifo_ram.sv | 23 ++
 rtl/fifo_sync.sv | 107 ++++++++++
 tb/tb_fifo_sync.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_sync family.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_REG  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Default almost-full threshold: two entries below full.
  function automatic int unsigned afull_default(input int unsigned asize);
    return (32'd1 << asize) - 32'd2;
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Handshake/data bundle between a FIFO user (master) and fifo_sync (slave).
interface fifo_sync_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
);
  logic             flush;
  logic             clr_err;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clr_err, wdata, winc, rinc,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wdata, winc, rinc,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DSIZE storage: clocked write port, asynchronous read port.
module fifo_ram #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata_c
);
  localparam int unsigned DEPTH = 32'd1 << ASIZE;

  logic [DSIZE-1:0] r_mem [DEPTH];

  // Write port; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[i_raddr];
endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered or first-word-fall-through read,
// exact fill level, almost flags, sticky error flags and synchronous flush.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE      = 8,
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned FWFT       = FIFO_MODE_REG,
  parameter int unsigned AFULL_THR  = afull_default(ASIZE),
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic       clk,
  input  logic       rst,
  fifo_sync_if.slave bus
);
  localparam int unsigned DEPTH = 32'd1 << ASIZE;
  localparam int unsigned CW    = ASIZE + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

  // Reject illegal configurations at elaboration.
  if (AFULL_THR == 0 || AFULL_THR > DEPTH) begin : g_bad_afull
    $error("fifo_sync: AFULL_THR must be in 1..DEPTH");
  end
  if (AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync: AEMPTY_THR must be in 0..DEPTH-1");
  end
  if (FWFT > FIFO_MODE_FWFT) begin : g_bad_mode
    $error("fifo_sync: FWFT must be 0 or 1");
  end

  logic [CW-1:0]    r_wptr, r_rptr, r_count;
  logic [CW-1:0]    w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  logic             w_wr_en, w_rd_en, w_ovf_nxt, w_udf_nxt;
  logic             r_wfull, r_walmost_full, r_rempty, r_ralmost_empty;
  logic             r_overflow, r_underflow;
  logic [DSIZE-1:0] w_ram_rdata;

  // Accept/reject decisions and next-state pointers, count and error flags.
  always_comb begin
    w_wr_en    = bus.winc && !r_wfull && !bus.flush;
    w_rd_en    = bus.rinc && !r_rempty && !bus.flush;
    w_wptr_nxt = bus.flush ? '0 : r_wptr + CW'(w_wr_en);
    w_rptr_nxt = bus.flush ? '0 : r_rptr + CW'(w_rd_en);
    w_count_nxt = w_wptr_nxt - w_rptr_nxt;
    w_ovf_nxt  = (bus.winc && r_wfull && !bus.flush) || (r_overflow && !bus.clr_err);
    w_udf_nxt  = (bus.rinc && r_rempty && !bus.flush) || (r_underflow && !bus.clr_err);
  end

  // Pointer, count and flag registers; flags follow the next-state count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_wfull         <= 1'b0;
      r_walmost_full  <= 1'b0;
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      r_wptr          <= w_wptr_nxt;
      r_rptr          <= w_rptr_nxt;
      r_count         <= w_count_nxt;
      r_wfull         <= (w_count_nxt == DEPTH_C);
      r_walmost_full  <= (w_count_nxt >= AFULL_C);
      r_rempty        <= (w_count_nxt == '0);
      r_ralmost_empty <= (w_count_nxt <= AEMPTY_C);
      r_overflow      <= w_ovf_nxt;
      r_underflow     <= w_udf_nxt;
    end
  end

  fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_ram (
    .clk      (clk),
    .i_we     (w_wr_en),
    .i_waddr  (r_wptr[ASIZE-1:0]),
    .i_wdata  (bus.wdata),
    .i_raddr  (r_rptr[ASIZE-1:0]),
    .o_rdata_c(w_ram_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign bus.rdata = w_ram_rdata;
  end else begin : g_reg
    logic [DSIZE-1:0] r_rdata;
    // Registered read: capture the head when a pop is accepted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_rdata <= '0;
      else if (w_rd_en) r_rdata <= w_ram_rdata;
    end
    assign bus.rdata = r_rdata;
  end

  assign bus.count         = r_count;
  assign bus.wfull         = r_wfull;
  assign bus.walmost_full  = r_walmost_full;
  assign bus.rempty        = r_rempty;
  assign bus.ralmost_empty = r_ralmost_empty;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: a registered-read and an FWFT instance driven with
// identical stimulus, checked against a queue-based reference model.
module tb_fifo_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_sync_if #(.DSIZE(8), .ASIZE(4)) b0 ();
  fifo_sync_if #(.DSIZE(8), .ASIZE(4)) b1 ();

  fifo_sync #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_reg  (.clk(clk), .rst(rst), .bus(b0));
  fifo_sync #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_fwft (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: contents as a queue, last popped word, sticky errors.
  logic [7:0] q[$];
  logic [7:0] m_last = 8'h00;
  bit         m_ovf  = 1'b0;
  bit         m_udf  = 1'b0;

  typedef struct {
    bit         flush;
    bit         clr_err;
    bit         winc;
    logic [7:0] wdata;
    bit         rinc;
    int         exp_count;
    logic [7:0] exp_rdata;
    bit         exp_udf;
    bit         exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input bit f, input bit ce, input bit wi, input logic [7:0] wd, input bit ri);
    b0.flush = f; b0.clr_err = ce; b0.winc = wi; b0.wdata = wd; b0.rinc = ri;
    b1.flush = f; b1.clr_err = ce; b1.winc = wi; b1.wdata = wd; b1.rinc = ri;
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("reg_count",   32'(b0.count),         32'(n));
    chk("fwft_count",  32'(b1.count),         32'(n));
    chk("reg_wfull",   32'(b0.wfull),         32'(n == 16));
    chk("fwft_wfull",  32'(b1.wfull),         32'(n == 16));
    chk("reg_afull",   32'(b0.walmost_full),  32'(n >= 14));
    chk("fwft_afull",  32'(b1.walmost_full),  32'(n >= 14));
    chk("reg_rempty",  32'(b0.rempty),        32'(n == 0));
    chk("fwft_rempty", 32'(b1.rempty),        32'(n == 0));
    chk("reg_aempty",  32'(b0.ralmost_empty), 32'(n <= 2));
    chk("fwft_aempty", 32'(b1.ralmost_empty), 32'(n <= 2));
    chk("reg_ovf",     32'(b0.overflow),      32'(m_ovf));
    chk("fwft_ovf",    32'(b1.overflow),      32'(m_ovf));
    chk("reg_udf",     32'(b0.underflow),     32'(m_udf));
    chk("fwft_udf",    32'(b1.underflow),     32'(m_udf));
    chk("reg_rdata",   32'(b0.rdata),         32'(m_last));
    if (n > 0) chk("fwft_rdata", 32'(b1.rdata), 32'(q[0]));
  endtask

  // One clock cycle: drive, advance the model, clock, then compare.
  task automatic step(input bit f, input bit ce, input bit wi, input logic [7:0] wd, input bit ri);
    bit full, empty, ovf_ev, udf_ev;
    drive(f, ce, wi, wd, ri);
    full   = (q.size() == 16);
    empty  = (q.size() == 0);
    ovf_ev = !f && wi && full;
    udf_ev = !f && ri && empty;
    if (f) q.delete();
    else begin
      if (ri && !empty) m_last = q.pop_front();
      if (wi && !full)  q.push_back(wd);
    end
    m_ovf = ovf_ev || (m_ovf && !ce);
    m_udf = udf_ev || (m_udf && !ce);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"},  32'(b0.count),         32'd0);
    chk({tag, "_rempty"}, 32'(b0.rempty),        32'd1);
    chk({tag, "_aempty"}, 32'(b0.ralmost_empty), 32'd1);
    chk({tag, "_wfull"},  32'(b0.wfull),         32'd0);
    chk({tag, "_afull"},  32'(b0.walmost_full),  32'd0);
    chk({tag, "_ovf"},    32'(b0.overflow),      32'd0);
    chk({tag, "_udf"},    32'(b0.underflow),     32'd0);
    chk({tag, "_rdata"},  32'(b0.rdata),         32'd0);
    chk({tag, "_fcount"}, 32'(b1.count),         32'd0);
    chk({tag, "_frempty"},32'(b1.rempty),        32'd1);
  endtask

  initial begin
    vec_t tbl [12];
    int   sel, len;

    drive(0, 0, 0, 8'h00, 0);
    #12;
    check_reset_values("reset");
    rst = 1'b0;

    // Underflow / clr_err and short data path, with hand-derived expectations.
    tbl[0]  = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0};
    tbl[1]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0};
    tbl[2]  = '{0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    tbl[3]  = '{0, 1, 0, 8'h00, 1, 0, 8'h00, 1, 0};
    tbl[4]  = '{0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    tbl[5]  = '{0, 0, 1, 8'h11, 0, 1, 8'h00, 0, 0};
    tbl[6]  = '{0, 0, 1, 8'h22, 0, 2, 8'h00, 0, 0};
    tbl[7]  = '{0, 0, 1, 8'h33, 1, 2, 8'h11, 0, 0};
    tbl[8]  = '{0, 0, 0, 8'h00, 1, 1, 8'h22, 0, 0};
    tbl[9]  = '{0, 0, 0, 8'h00, 1, 0, 8'h33, 0, 0};
    tbl[10] = '{0, 0, 0, 8'h00, 1, 0, 8'h33, 1, 0};
    tbl[11] = '{0, 1, 0, 8'h00, 0, 0, 8'h33, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].flush, tbl[i].clr_err, tbl[i].winc, tbl[i].wdata, tbl[i].rinc);
      chk($sformatf("tbl%0d_count", i), 32'(b0.count),     32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_rdata", i), 32'(b0.rdata),     32'(tbl[i].exp_rdata));
      chk($sformatf("tbl%0d_udf", i),   32'(b0.underflow), 32'(tbl[i].exp_udf));
      chk($sformatf("tbl%0d_ovf", i),   32'(b0.overflow),  32'(tbl[i].exp_ovf));
    end

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 8'(i), 0);
      chk("fill_afull", 32'(b0.walmost_full), 32'((i + 1) >= 14));
    end
    chk("fill_wfull", 32'(b0.wfull), 32'd1);
    chk("fill_count", 32'(b0.count), 32'd16);
    step(0, 0, 1, 8'hAA, 0);
    chk("ovf_set",   32'(b0.overflow), 32'd1);
    chk("ovf_count", 32'(b0.count),    32'd16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 8'h00, 1);
      chk("drain_data", 32'(b0.rdata), 32'(i));
    end
    chk("drain_rempty", 32'(b0.rempty), 32'd1);
    step(0, 1, 0, 8'h00, 0);
    chk("ovf_clr", 32'(b0.overflow), 32'd0);

    // Simultaneous access at count 8, then at full.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'($urandom), 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 8'($urandom), 1);
      chk("simul_count8", 32'(b0.count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'($urandom), 0);
    step(0, 0, 1, 8'hEE, 1);
    chk("full_rw_count", 32'(b0.count),    32'd15);
    chk("full_rw_ovf",   32'(b0.overflow), 32'd1);
    step(0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);

    // FWFT latency.
    step(0, 0, 1, 8'h5C, 0);
    chk("fwft_head",   32'(b1.rdata),  32'h5C);
    chk("fwft_nempty", 32'(b1.rempty), 32'd0);
    step(0, 0, 1, 8'h6D, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("fwft_next", 32'(b1.rdata), 32'h6D);
    step(0, 0, 0, 8'h00, 1);

    // Randomised bursts across pointer wrap.
    for (int b = 0; b < 40; b++) begin
      sel = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 8));
      for (int c = 0; c < len; c++) begin
        bit wi, ri, ce;
        wi = (sel == 0) ? ($urandom_range(0, 9) < 8) : (sel == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1) == 1;
        ri = (sel == 1) ? ($urandom_range(0, 9) < 8) : (sel == 0) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1) == 1;
        ce = ($urandom_range(0, 9) == 0);
        step(0, ce, wi, 8'($urandom), ri);
      end
    end

    // Flush at count 9 with concurrent winc/rinc.
    step(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 8'(8'h40 + i), 0);
    chk("pre_flush_count", 32'(b0.count), 32'd9);
    step(1, 0, 1, 8'h99, 1);
    chk("flush_count",  32'(b0.count),     32'd0);
    chk("flush_rempty", 32'(b0.rempty),    32'd1);
    chk("flush_ovf",    32'(b0.overflow),  32'd0);
    chk("flush_udf",    32'(b0.underflow), 32'd0);

    // Asynchronous reset between edges at count 5.
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(8'h71 + i), 0);
    step(0, 0, 0, 8'h00, 1);
    chk("pre_rst_count", 32'(b0.count), 32'd5);
    chk("pre_rst_rdata", 32'(b0.rdata), 32'h71);
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    q.delete();
    m_last = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    drive(0, 0, 0, 8'h00, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom), i[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
